// File: rtl/block_fifo_stage.sv
// block_fifo_stage: show-ahead FIFO of BSIZE-bit blocks between block assembler and disassembler
// Ports: clock/reset (async, active-high), clear (sync flush);
//   block_in/block_in_valid/block_in_hold: upstream side, hold is back-pressure;
//   block_out/block_out_valid/block_out_pull: head block presented continuously;
//   level: occupied slots 0..DEPTH; overflow: sticky, block offered while full.
module block_fifo_stage #(
  parameter int BSIZE = 128,
  parameter int DEPTH = 4,
  parameter int HOLD_MARGIN = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int LVLW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [BSIZE-1:0] block_in,
  input  logic             block_in_valid,
  output logic             block_in_hold,
  output logic [BSIZE-1:0] block_out,
  output logic             block_out_valid,
  input  logic             block_out_pull,
  output logic [LVLW-1:0]  level,
  output logic             overflow
);
  logic [BSIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop;
  always_comb begin
    full = level == LVLW'(DEPTH);
    empty = level == '0;
    push = block_in_valid & !full & !clear;
    pop = block_out_pull & !empty & !clear;
    block_out_valid = !empty;
    block_out = empty ? '0 : mem[rd_ptr];
    block_in_hold = (LVLW'(DEPTH) - level) <= LVLW'(HOLD_MARGIN);
  end
  // level, not the pointers, decides full/empty, so pointers simply wrap
  always_ff @(posedge clock or posedge reset)
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVLW'(push) - LVLW'(pop);
      if (block_in_valid && full) overflow <= 1'b1;
    end
  // storage is deliberately not reset; pointers reset gates any stale content
  always_ff @(posedge clock)
    if (push && !reset) mem[wr_ptr] <= block_in;
endmodule
